pc_display_ctrl: RTL



---
 rtl/pcdisp_pkg.sv | 30 +++
 rtl/pc_display_ctrl_if.sv | 25 ++
 rtl/pcdisp_seg_decode.sv | 25 ++
 rtl/pc_display_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/pcdisp_pkg.sv
// Shared types and constants for the PC display controller: FSM states,
// active-low 7-segment patterns and the internal BCD digit count.
package pcdisp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    // ceil(width * log10(2)) in fixed point; rounding up only ever adds a spare digit
    function automatic int nbcd(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/pc_display_ctrl_if.sv
// Load/display bus between the core-side driver (master) and the
// PC display controller (slave).
interface pc_display_ctrl_if #(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
);
    logic [WIDTH-1:0]    value_i;
    logic                load_i;
    logic                blank_i;
    logic                ready_o;
    logic                done_o;
    logic                neg_o;
    logic                ovf_o;
    logic [7*DIGITS-1:0] seg_o;

    modport master (
        output value_i, load_i, blank_i,
        input  ready_o, done_o, neg_o, ovf_o, seg_o
    );

    modport slave (
        input  value_i, load_i, blank_i,
        output ready_o, done_o, neg_o, ovf_o, seg_o
    );
endinterface

// File: rtl/pcdisp_seg_decode.sv
// One BCD digit to an active-low 7-segment pattern (bit 6 = g ... bit 0 = a).
module pcdisp_seg_decode
    import pcdisp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/pc_display_ctrl.sv
// Program-counter display controller: iterative double-dabble to DIGITS
// 7-segment digits with sign/overflow flags. Define PCDISP_LZB_EN for leading-zero blanking.
module pc_display_ctrl
    import pcdisp_pkg::*;
#(
    parameter int WIDTH     = 9,
    parameter int DIGITS    = 3,
    parameter bit SIGNED_IN = 1'b1
) (
    input logic              clock,
    input logic              reset_n,
    pc_display_ctrl_if.slave bus
);

    // Never narrower than the display so the digit decoders always have a nibble
    localparam int NB    = (nbcd(WIDTH) > DIGITS) ? nbcd(WIDTH) : DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    mag_q, mag_d;
    logic                sign_q, sign_d;
    logic [4*NB-1:0]     bcd_q, bcd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic                neg_q, neg_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    logic [4*NB-1:0]     bcd_adj;
    logic [7*DIGITS-1:0] dec_seg;
    logic [7*DIGITS-1:0] disp_c;
    logic                ovf_c;
    logic                seen_nz;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        pcdisp_seg_decode u_dec (
            .bcd_i (bcd_q[4*g +: 4]),
            .seg_o (dec_seg[7*g +: 7])
        );
    end

    always_comb begin
        ovf_c   = 1'b0;
        seen_nz = 1'b0;
        disp_c  = dec_seg;
        for (int i = 0; i < NB; i++) begin
            if (i >= DIGITS && bcd_q[4*i +: 4] != 4'd0) ovf_c = 1'b1;
        end
`ifdef PCDISP_LZB_EN
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (bcd_q[4*k +: 4] != 4'd0 || k == 0) seen_nz = 1'b1;
            disp_c[7*k +: 7] = seen_nz ? dec_seg[7*k +: 7] : SEG_BLANK;
        end
`endif
        if (ovf_c) disp_c = {DIGITS{SEG_DASH}};
    end

    // Double-dabble correction: any nibble >= 5 would carry wrongly after the shift
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < NB; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                          : bcd_q[4*i +: 4];
        end
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_i) begin
                    if (SIGNED_IN && bus.value_i[WIDTH-1]) begin
                        mag_d  = -bus.value_i;
                        sign_d = 1'b1;
                    end else begin
                        mag_d  = bus.value_i;
                        sign_d = 1'b0;
                    end
                    bcd_d   = '0;
                    cnt_d   = CNT_INIT;
                    state_d = CONV;
                end
            end
            CONV: begin
                {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                seg_d   = disp_c;
                ovf_d   = ovf_c;
                neg_d   = sign_q && (bcd_q != '0);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            seg_q   <= {DIGITS{SEG_BLANK}};
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready_o = (state_q == IDLE);
    assign bus.done_o  = done_q;
    assign bus.neg_o   = neg_q;
    assign bus.ovf_o   = ovf_q;
    assign bus.seg_o   = bus.blank_i ? {DIGITS{SEG_BLANK}} : seg_q;

endmodule
